// File: rtl/ofm_port_arbiter.sv
`default_nettype none
// ============================================================================
// ofm_port_arbiter : round-robin owner of the layer-1 OFM address/wen port,
//                    releasing layer-2 reads once completed writes cover them.
// Revision         : 1.0
// ============================================================================
module ofm_port_arbiter #(
  parameter int ADDR_W    = 8,
  parameter int DEPTH     = 172,
  parameter int MAX_BURST = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              frame_start_i,
  input  logic              l1_req_i,
  input  logic [ADDR_W-1:0] l1_addr_i,
  input  logic              l1_last_i,
  input  logic              l1_done_i,
  output logic              l1_gnt_o,
  input  logic              l2_req_i,
  input  logic [ADDR_W-1:0] l2_addr_i,
  input  logic              l2_last_i,
  output logic              l2_gnt_o,
  output logic              l2_rvalid_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic              mem_wen_o,
  output logic [ADDR_W:0]   wr_count_o,
  output logic              l1_complete_o,
  output logic              addr_err_o
);

  localparam int              c_bw       = $clog2(MAX_BURST + 1);
  localparam logic [ADDR_W:0] c_depth    = (ADDR_W + 1)'(DEPTH);
  localparam logic [c_bw-1:0] c_max_beat = c_bw'(MAX_BURST);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WR   = 2'd1,
    RD   = 2'd2
  } state_t;

  state_t          state_q;
  logic [c_bw-1:0] beat_q;
  logic [c_bw-1:0] beat_d;
  logic [ADDR_W:0] wr_count_q;
  logic            l1_complete_q;
  logic            addr_err_q;
  logic            l2_rvalid_q;
  logic            prefer_l1_q;

  logic w_block;
  logic w_safe;
  logic w_l1_in_rng;
  logic w_l2_in_rng;
  logic w_l1_gnt;
  logic w_l2_gnt;
  logic w_l2_elig;
  logic w_mem_wen;
  logic w_burst_end;

  // Reset and frame restart both squash any beat in the cycle they arrive.
  assign w_block     = rst | frame_start_i;
  assign w_safe      = ({1'b0, l2_addr_i} < wr_count_q) | l1_complete_q;
  assign w_l1_in_rng = ({1'b0, l1_addr_i} < c_depth);
  assign w_l2_in_rng = ({1'b0, l2_addr_i} < c_depth);
  assign w_l2_elig   = l2_req_i & w_safe;
  assign w_l1_gnt    = ~w_block & (state_q == WR) & l1_req_i;
  assign w_l2_gnt    = ~w_block & (state_q == RD) & w_l2_elig;
  assign w_mem_wen   = w_l1_gnt & w_l1_in_rng;
  assign beat_d      = beat_q + c_bw'(1);
  assign w_burst_end = (beat_d == c_max_beat);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      beat_q        <= '0;
      wr_count_q    <= '0;
      l1_complete_q <= 1'b0;
      addr_err_q    <= 1'b0;
      l2_rvalid_q   <= 1'b0;
      prefer_l1_q   <= 1'b1;
    end else if (frame_start_i) begin
      state_q       <= IDLE;
      beat_q        <= '0;
      wr_count_q    <= '0;
      l1_complete_q <= 1'b0;
      l2_rvalid_q   <= 1'b0;
      prefer_l1_q   <= 1'b1;
    end else begin
      l2_rvalid_q <= w_l2_gnt;
      if (w_mem_wen && (wr_count_q != c_depth)) begin
        wr_count_q <= wr_count_q + (ADDR_W + 1)'(1);
      end
      if ((w_l1_gnt && !w_l1_in_rng) || (w_l2_gnt && !w_l2_in_rng)) begin
        addr_err_q <= 1'b1;
      end
      if (l1_done_i) begin
        l1_complete_q <= 1'b1;
      end
      case (state_q)
        IDLE: begin
          if (l1_req_i && (!w_l2_elig || prefer_l1_q)) begin
            state_q     <= WR;
            beat_q      <= '0;
            prefer_l1_q <= 1'b0;
          end else if (w_l2_elig) begin
            state_q     <= RD;
            beat_q      <= '0;
            prefer_l1_q <= 1'b1;
          end
        end
        WR: begin
          if (!w_l1_gnt || l1_last_i || w_burst_end) begin
            state_q <= IDLE;
          end else begin
            beat_q <= beat_d;
          end
        end
        RD: begin
          // An unsafe read yields the port instead of holding it.
          if (!w_l2_gnt || l2_last_i || w_burst_end) begin
            state_q <= IDLE;
          end else begin
            beat_q <= beat_d;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign l1_gnt_o      = w_l1_gnt;
  assign l2_gnt_o      = w_l2_gnt;
  assign mem_wen_o     = w_mem_wen;
  assign mem_addr_o    = (state_q == WR) ? l1_addr_i :
                         (state_q == RD) ? l2_addr_i : '0;
  assign wr_count_o    = wr_count_q;
  assign l1_complete_o = l1_complete_q;
  assign addr_err_o    = addr_err_q;
  assign l2_rvalid_o   = l2_rvalid_q;

endmodule
`default_nettype wire

// File: doc/ofm_port_arbiter.md
Name: ofm_port_arbiter

Overview:
- Arbitrates the single address/write-enable port of the layer-1 OFM memory bank between two requesters: the layer-1 writer and the layer-2 window reader.
- Lets layer 2 start reading while layer 1 is still writing. A read is released only when its address is already covered by completed writes.
- Sits between the two layer controllers and the OFM memories, replacing static address-select muxing. One instance drives all N OFM banks in lockstep.

Parameters:
- ADDR_W, 8, width of OFM address.
- DEPTH, 172, number of valid OFM words per bank; valid addresses are 0..DEPTH-1.
- MAX_BURST, 16, maximum accepted beats per grant before the arbiter must re-arbitrate.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- frame_start  in  1  one-cycle pulse; clears progress state for a new image
- l1_req  in  1  layer-1 write request
- l1_addr  in  ADDR_W  layer-1 write address; sequential from 0
- l1_last  in  1  last beat of the current layer-1 burst
- l1_done  in  1  one-cycle pulse; layer 1 has finished all writes
- l1_gnt  out  1  layer-1 beat accepted this cycle
- l2_req  in  1  layer-2 read request
- l2_addr  in  ADDR_W  layer-2 read address
- l2_last  in  1  last beat of the current layer-2 burst
- l2_gnt  out  1  layer-2 beat accepted this cycle
- l2_rvalid  out  1  read data valid at the OFM outputs
- mem_addr  out  ADDR_W  address to all OFM banks
- mem_wen  out  1  write enable to all OFM banks
- wr_count  out  ADDR_W+1  number of completed layer-1 writes
- l1_complete  out  1  sticky flag: layer 1 finished
- addr_err  out  1  sticky flag: out-of-range address seen

Behaviour:
- State machine:
  - States: IDLE, WR, RD. Reset value is IDLE.
  - Outputs at reset: all outputs 0, wr_count=0, round-robin pointer favours L1.
- Eligibility:
  - L1 is eligible when l1_req=1.
  - L2 is eligible when l2_req=1 and the read is safe.
  - Safe means (l2_addr < wr_count) or l1_complete=1.
- IDLE arbitration, round robin:
  - If both are eligible, grant the one not served last.
  - If one is eligible, grant it.
  - The transition happens on the next edge. The first beat in WR/RD is therefore 1 cycle after the request is seen in IDLE.
- Grants are combinational from state:
  - l1_gnt = (state==WR) & l1_req.
  - l2_gnt = (state==RD) & l2_req & safe.
- Port outputs:
  - mem_addr = l1_addr in WR, l2_addr in RD, 0 in IDLE.
  - mem_wen = l1_gnt & (l1_addr < DEPTH).
- Beat counter:
  - Counts accepted beats in the current grant.
  - Cleared on entry to WR/RD.
- Leave WR/RD to IDLE (always via one IDLE turnaround cycle) when any of:
  - an accepted beat has last=1;
  - the beat counter reaches MAX_BURST;
  - the owner's req is low;
  - in RD, the current address is unsafe (yield, no stall-hold).
- wr_count:
  - Increments on each l1_gnt beat with l1_addr < DEPTH.
  - Saturates at DEPTH.
- l1_complete is set by l1_done and stays set until frame_start or rst.
- l2_rvalid is registered: it equals l2_gnt delayed by 1 cycle (1-cycle memory read latency).
- addr_err is set when either of these occurs, and stays set until rst:
  - l1_gnt with l1_addr >= DEPTH: the write is suppressed, wr_count unchanged;
  - l2_gnt with l2_addr >= DEPTH.
- frame_start takes priority over all other events in that cycle. It forces:
  - state to IDLE;
  - wr_count=0, l1_complete=0, l2_rvalid=0, round-robin pointer to L1.
- rst mid-burst: same effect as frame_start, plus addr_err=0. No write is issued in the reset cycle.
- Simultaneous l1_done and the final write beat: the count and the flag both update in the same cycle.

Test Plan:
- Reset, then l1_req with addresses 0..3, l1_last on addr 3:
  - l1_gnt high for 4 cycles starting 1 cycle after the request;
  - mem_wen=1 with mem_addr 0..3;
  - wr_count=4; then IDLE for 1 cycle.
- Reads against write progress:
  - After wr_count=4, l2_req at addr 2: l2_gnt=1 and l2_rvalid=1 on the next cycle.
  - l2_req at addr 5 with l1_complete=0: l2_gnt stays 0 and the FSM yields to IDLE.
- Both requesters continuously asserted, wr_count=100, MAX_BURST=16:
  - grants alternate WR/RD in bursts of 16 beats, separated by 1 IDLE cycle each.
- Full layer-1 run:
  - 172 sequential writes followed by l1_done: wr_count=172, l1_complete=1.
  - l2 read at addr 171 is granted immediately.
  - A 173rd write attempt at addr 172 sets addr_err with mem_wen=0.
- Abort mid-burst:
  - frame_start during the 5th beat of an RD burst: next cycle state=IDLE, wr_count=0, l1_complete=0, l2_rvalid=0.
  - A later read at addr 0 is not granted until a write occurs.
- rst asserted during a WR burst: next cycle all outputs are 0 and no mem_wen pulse occurs in or after the reset cycle.
